// File: rtl/lb_arb_pkg.sv
// Shared constants and grant encoding for the line-buffer port arbiter.
// Optional fairness build: LB_ARB_FAIR_EN (see lb_port_arbiter).
package lb_arb_pkg;
   localparam int DW    = 16;
   localparam int AW    = 11;
   localparam int DEPTH = 1027;
   localparam int ROW   = 512;

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2
   } gnt_e;
endpackage

// File: rtl/lb_mod_add.sv
// Ring-address adder: (a + b) mod DEPTH for operands already below DEPTH.
module lb_mod_add
   import lb_arb_pkg::*;
(
   input  logic [AW-1:0] i_a,
   input  logic [AW-1:0] i_b,
   output logic [AW-1:0] o_y
);
   logic [AW:0] w_sum;

   assign w_sum = {1'b0, i_a} + {1'b0, i_b};
   // One conditional subtract suffices since both operands are < DEPTH.
   assign o_y   = AW'((w_sum >= DEPTH_W) ? (w_sum - DEPTH_W) : w_sum);
endmodule

// File: rtl/lb_port_arbiter.sv
// Shares the single-port line buffer between the pixel writer and the tap reader.
// Define LB_ARB_FAIR_EN to let a starved reader win every 4th contended cycle.
module lb_port_arbiter
   import lb_arb_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_req,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ack,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_ofs,
   output logic          rd_ack,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   input  logic          adv,
   input  logic [1:0]    adv_step,
   output logic          adv_err,
   output logic [AW-1:0] fill,
   output logic          mem_csn,
   output logic          mem_wen,
   output logic [AW-1:0] mem_ad,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout
);
   logic          r_hold_v;
   logic [DW-1:0] r_hold_d;
   logic [AW-1:0] r_wptr, r_base, r_fill;
   logic          r_rd_pend, r_rd_valid, r_adv_err;
   logic [DW-1:0] r_rd_data;

   gnt_e          w_gnt;
   logic          w_rd_legal, w_drain, w_adv_ok, w_fair_rd;
   logic [AW-1:0] w_step, w_wptr_nx, w_rd_addr, w_base_nx;
   logic [AW:0]   w_occ;

   assign w_step     = AW'(adv_step);
   assign w_rd_legal = rd_req && (rd_ofs < r_fill);
   assign w_occ      = {1'b0, r_fill} + (AW+1)'(r_hold_v);
   // Guard uses pre-cycle fill; a same-cycle commit cannot cover an over-retire.
   assign w_adv_ok   = adv && (w_step <= r_fill);

   lb_mod_add u_wptr_inc (.i_a(r_wptr), .i_b(AW'(1)), .o_y(w_wptr_nx));
   lb_mod_add u_rd_addr  (.i_a(r_base), .i_b(rd_ofs), .o_y(w_rd_addr));
   lb_mod_add u_base_adv (.i_a(r_base), .i_b(w_step), .o_y(w_base_nx));

`ifdef LB_ARB_FAIR_EN
   logic [1:0] r_starve;

   assign w_fair_rd = w_rd_legal && (r_starve == 2'd3);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_starve <= 2'd0;
      else if (w_gnt == RD)
         r_starve <= 2'd0;
      else if ((w_gnt == WR) && w_rd_legal && (r_starve != 2'd3))
         r_starve <= r_starve + 2'd1;
   end
`else
   assign w_fair_rd = 1'b0;
`endif

   always_comb begin
      w_gnt = IDLE;
      if (r_hold_v && !w_fair_rd)
         w_gnt = WR;
      else if (w_rd_legal)
         w_gnt = RD;
   end

   assign w_drain = (w_gnt == WR);
   assign wr_ack  = wr_req && (!r_hold_v || w_drain) && (w_occ < DEPTH_W);
   assign rd_ack  = (w_gnt == RD);

   assign mem_csn = (w_gnt == IDLE);
   assign mem_wen = w_drain;
   assign mem_ad  = w_drain ? r_wptr : (rd_ack ? w_rd_addr : '0);
   assign mem_din = w_drain ? r_hold_d : '0;

   assign rd_valid = r_rd_valid;
   assign rd_data  = r_rd_data;
   assign adv_err  = r_adv_err;
   assign fill     = r_fill;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hold_v   <= 1'b0;
         r_hold_d   <= '0;
         r_wptr     <= '0;
         r_base     <= '0;
         r_fill     <= '0;
         r_rd_pend  <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_adv_err  <= 1'b0;
      end else begin
         if (wr_ack) begin
            r_hold_v <= 1'b1;
            r_hold_d <= wr_data;
         end else if (w_drain) begin
            r_hold_v <= 1'b0;
         end
         if (w_drain)
            r_wptr <= w_wptr_nx;
         if (w_adv_ok)
            r_base <= w_base_nx;
         r_fill    <= r_fill + AW'(w_drain) - (w_adv_ok ? w_step : '0);
         r_adv_err <= adv && !w_adv_ok;
         // Memory registers its output, so data is captured one edge after the grant edge.
         r_rd_pend  <= rd_ack;
         r_rd_valid <= r_rd_pend;
         if (r_rd_pend)
            r_rd_data <= mem_dout;
      end
   end
endmodule

// File: doc/lb_port_arbiter.md
# lb_port_arbiter

Sequencer and arbiter that shares the single-port 1027-entry line buffer between a streaming pixel writer and a 3x3 window-tap reader. It owns the circular write pointer, the read base pointer and the occupancy count. It decides each cycle which requester drives the memory port. It sits between the pixel input stage and the convolution engine, directly in front of the `linebuffer` instance.

## Interface
- DW, 16, pixel data width
- AW, 11, line-buffer address width
- DEPTH, 1027, ring size in entries (2 rows of 512 plus 3)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- wr_req  in  1  writer has a pixel
- wr_data  in  DW  pixel value
- wr_ack  out  1  pixel accepted this cycle
- rd_req  in  1  reader requests one tap
- rd_ofs  in  AW  tap offset from read base, legal range 0..DEPTH-1
- rd_ack  out  1  tap request granted this cycle
- rd_valid  out  1  rd_data valid, one cycle after rd_ack
- rd_data  out  DW  tap value
- adv  in  1  retire entries at read base
- adv_step  in  2  number of entries to retire, 1..3 (0 is a no-op)
- adv_err  out  1  one-cycle pulse when adv is rejected
- fill  out  AW  committed, unretired entries
- mem_csn  out  1  memory chip select, active-low
- mem_wen  out  1  1 = write, 0 = read
- mem_ad  out  AW  memory address
- mem_din  out  DW  write data
- mem_dout  in  DW  read data, registered inside memory (1-cycle latency)

## Operation
- Write holding register (hold_v, hold_d, one entry). The writer only ever loads this register; the memory is written only from it.
- wr_ack = wr_req && (!hold_v || drain) && (fill + hold_v < DEPTH). Here drain means the hold register is committed to memory this cycle.
- Port grant, strict priority:
  - If hold_v: write cycle. mem_wen=1, mem_ad=w_ptr, mem_din=hold_d. Then w_ptr advances with wrap at DEPTH-1 → 0, and fill increments.
  - Otherwise, if rd_req && rd_ofs < fill: read cycle. rd_ack=1, mem_wen=0, mem_ad=(r_base+rd_ofs) mod DEPTH.
  - Otherwise the port is idle: mem_csn=1.
- Read with rd_ofs ≥ fill: rd_ack stays 0 (data not written yet). The reader holds rd_req/rd_ofs stable until acked.
- adv with adv_step ≤ fill: r_base += adv_step mod DEPTH, fill -= adv_step. adv with adv_step > fill: no state change, adv_err=1 for that cycle.
- Write commit and adv in the same cycle: fill' = fill + 1 − adv_step, evaluated before the guard. The guard uses the pre-cycle fill.
- Modular add: compute the sum at AW+1 bits; if the sum ≥ DEPTH, subtract DEPTH. Operands are always < DEPTH.
- Full condition: fill + hold_v == DEPTH, so wr_ack=0. Empty condition: fill == 0, so every rd_req stalls and any nonzero adv errs.

## Timing
- wr_ack, rd_ack and mem_* are combinational from registered state plus requests. There is no combinational path from mem_dout.
- Write latency: wr_data is accepted at edge N and written to memory at edge N+1 at the earliest. fill reflects it after N+1.
- Read latency: rd_ack at edge N; rd_valid=1 and rd_data=mem_dout after edge N+1 (registered).
- Reset (rst=0, asynchronous): hold_v=0, w_ptr=0, r_base=0, fill=0, rd_valid=0, rd_data=0, adv_err=0. Consequently wr_ack=0, rd_ack=0, mem_csn=1, mem_wen=0, mem_ad=0, mem_din=0.
- Reset mid-operation discards the held pixel and any in-flight read. rd_valid does not fire after reset release.

## Configuration
- LB_ARB_FAIR_EN defined: a 2-bit starvation counter increments on each cycle where rd_req is legal but a write wins, and clears on any read grant.
  - When the counter reaches 3 and rd_req is legal, the read wins the next contended cycle.
  - The hold register stays full during that cycle, so wr_ack=0 unless hold_v=0.
- LB_ARB_FAIR_EN undefined: strict write priority, no counter logic present.

## Structure
- Package lb_arb_pkg holds DW, AW, DEPTH, ROW=512, and the port-grant encoding type (IDLE, WR, RD).
- Sub-module lb_mod_add: (a, b) → (a+b) mod DEPTH, combinational. Instantiate it for w_ptr+1, r_base+rd_ofs and r_base+adv_step.

## Test plan
- Reset, then drive 5 pixels 0x0001..0x0005 back-to-back. Expect wr_ack on all 5, mem writes to addresses 0..4, fill=5 two cycles after the last pixel.
- Fill to 1027 entries, then hold wr_req=1. Expect wr_ack=0 every cycle. After adv with adv_step=3, expect exactly 3 more acks and the next write at address 0 (wrap).
- With r_base=1025 and fill=10, read rd_ofs=4. Expect mem_ad=2, rd_valid one cycle after rd_ack, rd_data equal to the value written at address 2.
- Continuous wr_req while rd_req is pending, without LB_ARB_FAIR_EN: rd_ack=0 throughout. With the macro: rd_ack=1 on the 4th contended cycle.
- With fill=2, pulse adv with adv_step=3: expect adv_err=1 for one cycle and fill stays 2. A simultaneous write commit with adv_step=1 at fill=2 leaves fill=2.
- Assert rst=0 mid-stream with hold_v=1 and a read in flight: expect fill=0, rd_valid=0, and no memory write on the following cycles.
